// File: rtl/cache_pkg.sv
// Shared cache constants and the line-fill FSM state type (also used by cache4way).
package cache_pkg;

    localparam int CACHE_ADR_WIDTH   = 32'd32;
    localparam int CACHE_WORD_WIDTH  = 32'd32;
    localparam int CACHE_WORD_OFFSET = 32'd2;
    localparam int BYTE_OFFSET       = 32'd2;
    localparam int WORDS_PER_LINE    = 32'd4;
    localparam int CACHE_LINE_WIDTH  = CACHE_WORD_WIDTH * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } mshr_state_t;

endpackage

// File: rtl/mshr_line_buf.sv
// Line assembly buffer: one register per word slot, indexed write with
// write-miss merge, flattened read-out (word i in the i-th DATA_WIDTH field).
module mshr_line_buf
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH    = CACHE_WORD_WIDTH,
    parameter int WORD_OFFSET   = CACHE_WORD_OFFSET,
    parameter int DATAMEM_WIDTH = CACHE_LINE_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_wr_en,
    input  logic [WORD_OFFSET-1:0]   i_wr_idx,
    input  logic                     i_merge,
    input  logic [DATA_WIDTH-1:0]    i_mem_dat,
    input  logic [DATA_WIDTH-1:0]    i_merge_dat,
    output logic [DATAMEM_WIDTH-1:0] o_line
);

    localparam int NWORDS = 32'd1 << WORD_OFFSET;

    logic [DATA_WIDTH-1:0] r_slot [NWORDS];
    logic [DATA_WIDTH-1:0] w_wr_dat;

    // Write-miss data replaces the memory word destined for the critical slot.
    always_comb begin
        if (i_merge) begin
            w_wr_dat = i_merge_dat;
        end else begin
            w_wr_dat = i_mem_dat;
        end
    end

    // Slot storage: cleared on reset and at each new accept, one slot written per ack.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            for (int i = 0; i < NWORDS; i++) begin
                r_slot[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_slot[i_wr_idx] <= w_wr_dat;
        end
    end

    // Flatten the slots into the line bus presented to the data array.
    always_comb begin
        o_line = '0;
        for (int i = 0; i < NWORDS; i++) begin
            o_line[i*DATA_WIDTH +: DATA_WIDTH] = r_slot[i];
        end
    end

endmodule

// File: rtl/mshr_linefill.sv
// Single-entry miss-status / line-fill engine: fetches a line critical-word-first
// with wrap-around, merges write-miss data, forwards the critical word of a read
// miss early and hands the assembled line to the cache in a one-cycle FILL.
module mshr_linefill
    import cache_pkg::*;
#(
    parameter int ADR_WIDTH     = CACHE_ADR_WIDTH,
    parameter int DATA_WIDTH    = CACHE_WORD_WIDTH,
    parameter int WORD_OFFSET   = CACHE_WORD_OFFSET,
    parameter int DATAMEM_WIDTH = CACHE_LINE_WIDTH
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       miss_cc2mshr,
    input  logic [ADR_WIDTH-1:0]                       adr_cc2mshr,
    input  logic                                       rdwr_cc2mshr,
    input  logic [DATA_WIDTH-1:0]                      wdat_cc2mshr,
    output logic                                       busy_mshr2cc,
    output logic                                       req_mshr2mem,
    output logic [ADR_WIDTH-1:0]                       adr_mshr2mem,
    input  logic                                       ack_mem2mshr,
    input  logic [DATA_WIDTH-1:0]                      dat_mem2mshr,
    output logic                                       crit_vld_mshr2cc,
    output logic [DATA_WIDTH-1:0]                      crit_dat_mshr2cc,
    output logic                                       fill_mshr2cc,
    output logic [DATAMEM_WIDTH-1:0]                   line_mshr2cc,
    output logic [ADR_WIDTH-WORD_OFFSET-BYTE_OFFSET-1:0] ladr_mshr2cc
);

    localparam int LADR_WIDTH = ADR_WIDTH - WORD_OFFSET - BYTE_OFFSET;
    localparam logic [WORD_OFFSET-1:0] K_ZERO = '0;
    localparam logic [WORD_OFFSET-1:0] K_ONE  = {{(WORD_OFFSET-1){1'b0}}, 1'b1};
    localparam logic [WORD_OFFSET-1:0] K_LAST = '1;

    mshr_state_t             r_state;
    mshr_state_t             w_next_state;
    logic [LADR_WIDTH-1:0]   r_ladr;
    logic [WORD_OFFSET-1:0]  r_s;
    logic [WORD_OFFSET-1:0]  r_k;
    logic                    r_rdwr;
    logic [DATA_WIDTH-1:0]   r_wdat;
    logic                    r_crit_vld;
    logic [DATA_WIDTH-1:0]   r_crit_dat;

    logic                    w_busy;
    logic                    w_req;
    logic                    w_fill;
    logic                    w_accept;
    logic                    w_ack_fetch;
    logic                    w_first_ack;
    logic                    w_merge;
    logic [WORD_OFFSET-1:0]  w_idx;
    logic                    w_unused_adr_lsb;

    // Byte-offset bits never reach the word-aligned memory port.
    assign w_unused_adr_lsb = ^adr_cc2mshr[BYTE_OFFSET-1:0];

    // State register; reset dominates any same-edge miss or ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: FETCH ends on the ack of the last word, FILL lasts one cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (miss_cc2mshr) begin
                    w_next_state = FETCH;
                end else begin
                    w_next_state = IDLE;
                end
            end
            FETCH: begin
                if (ack_mem2mshr && (r_k == K_LAST)) begin
                    w_next_state = FILL;
                end else begin
                    w_next_state = FETCH;
                end
            end
            FILL:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode of the state register.
    always_comb begin
        w_busy = 1'b0;
        w_req  = 1'b0;
        w_fill = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
            end
            FETCH: begin
                w_busy = 1'b1;
                w_req  = 1'b1;
            end
            FILL: begin
                w_busy = 1'b1;
                w_fill = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Handshake qualifiers and the wrapped word index (s + k) mod line size.
    always_comb begin
        w_accept    = (r_state == IDLE) && miss_cc2mshr;
        w_ack_fetch = w_req && ack_mem2mshr;
        w_first_ack = w_ack_fetch && (r_k == K_ZERO);
        w_merge     = r_rdwr && (r_k == K_ZERO);
        w_idx       = r_s + r_k;
    end

    // Miss capture, word counter and the critical-word forward register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ladr     <= '0;
            r_s        <= '0;
            r_k        <= '0;
            r_rdwr     <= 1'b0;
            r_wdat     <= '0;
            r_crit_vld <= 1'b0;
            r_crit_dat <= '0;
        end else begin
            r_crit_vld <= w_first_ack && !r_rdwr;
            if (w_first_ack && !r_rdwr) begin
                r_crit_dat <= dat_mem2mshr;
            end
            if (w_accept) begin
                r_ladr <= adr_cc2mshr[ADR_WIDTH-1 -: LADR_WIDTH];
                r_s    <= adr_cc2mshr[BYTE_OFFSET +: WORD_OFFSET];
                r_rdwr <= rdwr_cc2mshr;
                r_wdat <= wdat_cc2mshr;
                r_k    <= K_ZERO;
            end else if (w_ack_fetch) begin
                r_k <= r_k + K_ONE;
            end
        end
    end

    // Fetch address is word aligned and only driven while a request is open.
    always_comb begin
        if (w_req) begin
            adr_mshr2mem = {r_ladr, w_idx, {BYTE_OFFSET{1'b0}}};
        end else begin
            adr_mshr2mem = '0;
        end
    end

    assign busy_mshr2cc     = w_busy;
    assign req_mshr2mem     = w_req;
    assign fill_mshr2cc     = w_fill;
    assign crit_vld_mshr2cc = r_crit_vld;
    assign crit_dat_mshr2cc = r_crit_dat;
    assign ladr_mshr2cc     = r_ladr;

    mshr_line_buf #(
        .DATA_WIDTH    (DATA_WIDTH),
        .WORD_OFFSET   (WORD_OFFSET),
        .DATAMEM_WIDTH (DATAMEM_WIDTH)
    ) u_line_buf (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_accept),
        .i_wr_en     (w_ack_fetch),
        .i_wr_idx    (w_idx),
        .i_merge     (w_merge),
        .i_mem_dat   (dat_mem2mshr),
        .i_merge_dat (r_wdat),
        .o_line      (line_mshr2cc)
    );

endmodule

// File: tb/tb_mshr_linefill.sv
// Directed self-checking bench for mshr_linefill.
module tb_mshr_linefill;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_cc2mshr;
    logic [31:0]  adr_cc2mshr;
    logic         rdwr_cc2mshr;
    logic [31:0]  wdat_cc2mshr;
    logic         busy_mshr2cc;
    logic         req_mshr2mem;
    logic [31:0]  adr_mshr2mem;
    logic         ack_mem2mshr;
    logic [31:0]  dat_mem2mshr;
    logic         crit_vld_mshr2cc;
    logic [31:0]  crit_dat_mshr2cc;
    logic         fill_mshr2cc;
    logic [127:0] line_mshr2cc;
    logic [27:0]  ladr_mshr2cc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0][31:0] t4_adr;
    logic [3:0][31:0] t4_mem;
    logic [3:0][31:0] t4b_dat;

    mshr_linefill dut (
        .clk              (clk),
        .rst              (rst),
        .miss_cc2mshr     (miss_cc2mshr),
        .adr_cc2mshr      (adr_cc2mshr),
        .rdwr_cc2mshr     (rdwr_cc2mshr),
        .wdat_cc2mshr     (wdat_cc2mshr),
        .busy_mshr2cc     (busy_mshr2cc),
        .req_mshr2mem     (req_mshr2mem),
        .adr_mshr2mem     (adr_mshr2mem),
        .ack_mem2mshr     (ack_mem2mshr),
        .dat_mem2mshr     (dat_mem2mshr),
        .crit_vld_mshr2cc (crit_vld_mshr2cc),
        .crit_dat_mshr2cc (crit_dat_mshr2cc),
        .fill_mshr2cc     (fill_mshr2cc),
        .line_mshr2cc     (line_mshr2cc),
        .ladr_mshr2cc     (ladr_mshr2cc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete miss: accept, four acks (mem indexed by word slot), FILL, back to IDLE.
    task automatic run_miss(input string tag, input logic [31:0] adr, input logic rdwr,
                            input logic [31:0] wdat, input logic [3:0][31:0] mem,
                            input logic [3:0][31:0] exp_adr, input int gap,
                            input logic exp_crit, input logic [31:0] exp_crit_dat,
                            input logic [127:0] exp_line, input logic [27:0] exp_ladr);
        miss_cc2mshr = 1'b1;
        adr_cc2mshr  = adr;
        rdwr_cc2mshr = rdwr;
        wdat_cc2mshr = wdat;
        tick();
        miss_cc2mshr = 1'b0;
        check({tag, "_busy_up"}, busy_mshr2cc, 1);
        check({tag, "_req_up"}, req_mshr2mem, 1);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_fetch_adr"}, adr_mshr2mem, exp_adr[i]);
            ack_mem2mshr = 1'b1;
            dat_mem2mshr = mem[exp_adr[i][3:2]];
            tick();
            ack_mem2mshr = 1'b0;
            dat_mem2mshr = 32'h0;
            if (i == 0) begin
                check({tag, "_crit_vld"}, crit_vld_mshr2cc, exp_crit);
                if (exp_crit) begin
                    check({tag, "_crit_dat"}, crit_dat_mshr2cc, exp_crit_dat);
                end
            end
            if (i == 1) begin
                check({tag, "_crit_pulse_end"}, crit_vld_mshr2cc, 0);
            end
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    check({tag, "_req_held"}, req_mshr2mem, 1);
                    tick();
                end
            end
        end
        check({tag, "_fill"}, fill_mshr2cc, 1);
        check({tag, "_fill_busy"}, busy_mshr2cc, 1);
        check({tag, "_fill_req"}, req_mshr2mem, 0);
        check({tag, "_line"}, line_mshr2cc, exp_line);
        check({tag, "_ladr"}, ladr_mshr2cc, exp_ladr);
        tick();
        check({tag, "_idle_fill"}, fill_mshr2cc, 0);
        check({tag, "_idle_busy"}, busy_mshr2cc, 0);
        check({tag, "_line_hold"}, line_mshr2cc, exp_line);
    endtask

    initial begin
        rst          = 1'b1;
        miss_cc2mshr = 1'b0;
        adr_cc2mshr  = 32'h0;
        rdwr_cc2mshr = 1'b0;
        wdat_cc2mshr = 32'h0;
        ack_mem2mshr = 1'b0;
        dat_mem2mshr = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", busy_mshr2cc, 0);
        check("rst_req", req_mshr2mem, 0);
        check("rst_adr", adr_mshr2mem, 0);
        check("rst_fill", fill_mshr2cc, 0);
        check("rst_crit", crit_vld_mshr2cc, 0);
        check("rst_line", line_mshr2cc, 0);
        check("rst_ladr", ladr_mshr2cc, 0);

        // Read miss, s=2, acks every other cycle.
        run_miss("rd", 32'hFF07BD08, 1'b0, 32'h0,
                 {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000},
                 {32'hFF07BD04, 32'hFF07BD00, 32'hFF07BD0C, 32'hFF07BD08},
                 1, 1'b1, 32'hA0000002,
                 128'hA0000003_A0000002_A0000001_A0000000, 28'hFF07BD0);

        // Write miss, s=0, back-to-back acks, merged critical word.
        run_miss("wr", 32'hFFFFFD00, 1'b1, 32'hAA8AAAA4,
                 {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                 {32'hFFFFFD0C, 32'hFFFFFD08, 32'hFFFFFD04, 32'hFFFFFD00},
                 0, 1'b0, 32'h0,
                 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_AA8AAAA4, 28'hFFFFFD0);

        // Second miss held high during FETCH and FILL; accepted once busy drops.
        t4_adr  = {32'h0000123C, 32'h00001238, 32'h00001234, 32'h00001230};
        t4_mem  = {32'hD0000003, 32'hD0000002, 32'hD0000001, 32'hD0000000};
        t4b_dat = {32'hE0000001, 32'hE0000000, 32'hE0000003, 32'hE0000002};
        miss_cc2mshr = 1'b1;
        adr_cc2mshr  = 32'h00001230;
        rdwr_cc2mshr = 1'b0;
        tick();
        adr_cc2mshr = 32'hD500AD08;
        for (int i = 0; i < 4; i++) begin
            check("hold_fetch_adr", adr_mshr2mem, t4_adr[i]);
            ack_mem2mshr = 1'b1;
            dat_mem2mshr = t4_mem[i];
            tick();
        end
        dat_mem2mshr = 32'hDEADBEEF;
        check("hold_fill", fill_mshr2cc, 1);
        check("hold_fill_ladr", ladr_mshr2cc, 28'h0000123);
        tick();
        ack_mem2mshr = 1'b0;
        check("hold_idle_busy", busy_mshr2cc, 0);
        check("hold_idle_req", req_mshr2mem, 0);
        check("hold_fill_ack_ignored", line_mshr2cc, 128'hD0000003_D0000002_D0000001_D0000000);
        tick();
        miss_cc2mshr = 1'b0;
        check("hold_accept_req", req_mshr2mem, 1);
        check("hold_accept_adr", adr_mshr2mem, 32'hD500AD08);
        for (int i = 0; i < 4; i++) begin
            ack_mem2mshr = 1'b1;
            dat_mem2mshr = t4b_dat[i];
            tick();
        end
        ack_mem2mshr = 1'b0;
        check("hold2_fill", fill_mshr2cc, 1);
        check("hold2_line", line_mshr2cc, 128'hE0000003_E0000002_E0000001_E0000000);
        check("hold2_ladr", ladr_mshr2cc, 28'hD500AD0);
        tick();

        // Reset after the second ack, colliding with a miss and an ack.
        miss_cc2mshr = 1'b1;
        adr_cc2mshr  = 32'h00000040;
        rdwr_cc2mshr = 1'b0;
        tick();
        miss_cc2mshr = 1'b0;
        ack_mem2mshr = 1'b1;
        dat_mem2mshr = 32'h11111111;
        tick();
        dat_mem2mshr = 32'h22222222;
        tick();
        rst          = 1'b1;
        miss_cc2mshr = 1'b1;
        dat_mem2mshr = 32'h33333333;
        tick();
        rst          = 1'b0;
        miss_cc2mshr = 1'b0;
        check("mrst_busy", busy_mshr2cc, 0);
        check("mrst_req", req_mshr2mem, 0);
        check("mrst_adr", adr_mshr2mem, 0);
        check("mrst_fill", fill_mshr2cc, 0);
        check("mrst_crit_vld", crit_vld_mshr2cc, 0);
        check("mrst_crit_dat", crit_dat_mshr2cc, 0);
        check("mrst_line", line_mshr2cc, 0);
        check("mrst_ladr", ladr_mshr2cc, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stray_ack_fill", fill_mshr2cc, 0);
            check("stray_ack_busy", busy_mshr2cc, 0);
        end
        check("stray_ack_line", line_mshr2cc, 0);
        ack_mem2mshr = 1'b0;

        // Wrap case s=3, word 3 first; also the post-reset recovery miss.
        run_miss("wrap", 32'hA5552D0C, 1'b0, 32'h0,
                 {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000},
                 {32'hA5552D08, 32'hA5552D04, 32'hA5552D00, 32'hA5552D0C},
                 2, 1'b1, 32'hC0DE0003,
                 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000, 28'hA5552D0);

        // Spurious ack while idle.
        ack_mem2mshr = 1'b1;
        dat_mem2mshr = 32'hDEADBEEF;
        tick();
        tick();
        ack_mem2mshr = 1'b0;
        check("idle_ack_busy", busy_mshr2cc, 0);
        check("idle_ack_req", req_mshr2mem, 0);
        check("idle_ack_fill", fill_mshr2cc, 0);
        check("idle_ack_crit", crit_vld_mshr2cc, 0);
        check("idle_ack_line", line_mshr2cc, 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
